// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings and the datapath width.
package cpu_pkg;
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;
endpackage

// File: rtl/alu.sv
// Purely combinational 8-operation unsigned ALU with a single carry/flag output.
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             carry
);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic               lt;
    logic               eq;
    logic               gt;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign lt   = (a < b);
    assign eq   = (a == b);
    assign gt   = (a > b);

    always_comb begin
        out   = '0;
        carry = 1'b0;
        case (sel)
            OP_ADD: begin
                out   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                out   = a - b;
                carry = lt;
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_MUL: begin
                out   = prod[WIDTH-1:0];
                carry = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                // Divide-by-zero saturates the quotient and raises the flag.
                if (b == '0) begin
                    out   = '1;
                    carry = 1'b1;
                end else begin
                    out = a / b;
                end
            end
            OP_CMP: begin
                out   = {{(WIDTH-3){1'b0}}, lt, eq, gt};
                carry = lt;
            end
            default: begin
                out   = '0;
                carry = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instruction_memory.sv
// Execute stage: latches one instruction per cycle, evaluates it in the ALU,
// and captures the result one cycle later for writeback.
module instruction_memory
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] ir_a;
    logic [WIDTH-1:0] ir_b;
    logic [2:0]       ir_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_a  <= '0;
            ir_b  <= '0;
            ir_op <= OP_ADD;
        end else begin
            ir_a  <= a;
            ir_b  <= b;
            ir_op <= opcode;
        end
    end

    assign alu_sel = ir_op;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a     (ir_a),
        .b     (ir_b),
        .sel   (ir_op),
        .out   (alu_out),
        .carry (carry_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else begin
            data_out <= alu_out;
        end
    end
endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for the execute stage with a queue-based scoreboard of ALU results.
module tb_instruction_memory;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] opcode = '0;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;
    logic [7:0] data_out;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] out;
        logic       c;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] prev_out = '0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    instruction_memory dut (
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .carry_out(carry_out),
        .clk      (clk),
        .reset    (reset),
        .data_out (data_out)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        exp_t e;
        int   r;
        e.sel = op;
        e.c   = 1'b0;
        e.out = '0;
        case (op)
            3'd0: begin r = int'(x) + int'(y); e.out = r[7:0]; e.c = (r > 255); end
            3'd1: begin r = int'(x) - int'(y); e.out = r[7:0]; e.c = (x < y); end
            3'd2: e.out = x & y;
            3'd3: e.out = x | y;
            3'd4: e.out = x ^ y;
            3'd5: begin r = int'(x) * int'(y); e.out = r[7:0]; e.c = (r > 255); end
            3'd6: begin
                if (y == 0) begin e.out = 8'hFF; e.c = 1'b1; end
                else e.out = x / y;
            end
            default: begin
                e.out = (x < y) ? 8'h04 : (x == y) ? 8'h02 : 8'h01;
                e.c   = (x < y);
            end
        endcase
        e.tag = $sformatf("op%0d_%0d_%0d", op, x, y);
        return e;
    endfunction

    // Drive one instruction, then after the edge compare against the scoreboard head.
    task automatic step(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op, input logic [7:0] lit);
        exp_t e;
        a = x; b = y; opcode = op;
        e = model(x, y, op);
        total++;
        assert (e.out === lit) else begin
            bad++;
            $error("FAIL model_%s observed=%0d expected=%0d", e.tag, e.out, lit);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_out"}, alu_out, e.out);
        check({e.tag, "_carry"}, {7'd0, carry_out}, {7'd0, e.c});
        check({e.tag, "_sel"}, {5'd0, alu_sel}, {5'd0, e.sel});
        check({e.tag, "_data"}, data_out, prev_out);
        $display("txn %s alu_out=%0d carry=%0d data_out=%0d", e.tag, alu_out, carry_out, data_out);
        prev_out = e.out;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, {5'd0, alu_sel}, 8'd0);
        check({tag, "_out"}, alu_out, 8'd0);
        check({tag, "_carry"}, {7'd0, carry_out}, 8'd0);
        check({tag, "_data"}, data_out, 8'd0);
    endtask

    initial begin
        // Reset held with random inputs and the clock running.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
            @(posedge clk);
            #1;
        end
        check_reset_outputs("rst_hold");
        #2 reset = 1'b1;
        #1;
        prev_out = '0;

        step(8'd5, 8'd3, 3'd0, 8'd8);
        step(8'd5, 8'd3, 3'd0, 8'd8);

        // Opcode sweep with a mid-stream asynchronous reset.
        step(8'd5, 8'd3, 3'd0, 8'd8);
        step(8'd5, 8'd3, 3'd1, 8'd2);
        step(8'd5, 8'd3, 3'd2, 8'd1);
        step(8'd5, 8'd3, 3'd3, 8'd7);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        a = 8'd77; b = 8'd66; opcode = 3'd5;
        #2 reset = 1'b1;
        prev_out = '0;
        sb.delete();
        step(8'd5, 8'd3, 3'd4, 8'd6);
        step(8'd5, 8'd3, 3'd5, 8'd15);
        step(8'd5, 8'd3, 3'd6, 8'd1);
        step(8'd5, 8'd3, 3'd7, 8'h01);

        // Flags and wrap-around.
        step(8'd200, 8'd100, 3'd0, 8'd44);
        step(8'd3, 8'd5, 3'd1, 8'd254);
        step(8'd20, 8'd20, 3'd5, 8'd144);
        // Division edges.
        step(8'd7, 8'd2, 3'd6, 8'd3);
        step(8'd9, 8'd0, 3'd6, 8'hFF);
        // Compare cases.
        step(8'd3, 8'd5, 3'd7, 8'h04);
        step(8'd5, 8'd5, 3'd7, 8'h02);
        step(8'd9, 8'd1, 3'd7, 8'h01);
        // Trailing instruction flushes the last writeback into data_out.
        step(8'd0, 8'd0, 3'd2, 8'd0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_memory.md
# instruction_memory

Instruction-execute stage of the 8-bit CPU. Each clock it latches one instruction (two operands plus a 3-bit opcode) into an instruction register and evaluates it in an 8-operation ALU. The result is exposed combinationally and also captured one cycle later in a data register for writeback. It sits between the instruction source (fetch/testbench) and the register file.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; all statements below use WIDTH=8.

Ports (clock and reset first):
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `a`  input  8  operand A.
- `b`  input  8  operand B.
- `opcode`  input  3  operation select.
- `alu_sel`  output  3  latched opcode currently executing.
- `alu_out`  output  8  combinational ALU result of latched instruction.
- `carry_out`  output  1  combinational flag of latched instruction.
- `data_out`  output  8  registered result (writeback).

Positional port order: a, b, opcode, alu_sel, alu_out, carry_out, clk, reset, data_out.

## Operation
- Instruction register: `ir_a`, `ir_b`, `ir_op` load `a`, `b`, `opcode` every rising edge when reset is deasserted; there is no enable.
- `alu_sel` = `ir_op`.
- ALU, on `ir_a` (A) and `ir_b` (B), unsigned:
  - 000 ADD: out = (A+B)[7:0]; carry = bit 8 of the 9-bit sum.
  - 001 SUB: out = (A−B)[7:0]; carry = 1 when A<B (borrow).
  - 010 AND: out = A&B; carry = 0.
  - 011 OR: out = A|B; carry = 0.
  - 100 XOR: out = A^B; carry = 0.
  - 101 MUL: out = (A*B)[7:0]; carry = 1 when (A*B)[15:8] ≠ 0.
  - 110 DIV: out = A/B (quotient, truncated); carry = 0. B=0: out = 8'hFF, carry = 1 (divide-by-zero flag).
  - 111 CMP: out = {5'b0, A<B, A==B, A>B}; carry = (A<B).
- Data register: `data_out` loads `alu_out` every rising edge.
- Exactly one of CMP bits [2:0] is set.

## Timing
- Reset (reset=0, asynchronous): `ir_a`, `ir_b`, `ir_op`, and `data_out` clear to 0 immediately, without waiting for a clock edge. Resulting outputs: `alu_sel`=0, `alu_out`=0 (ADD 0+0), `carry_out`=0, `data_out`=0.
- Reset release: takes effect synchronously. The first load happens on the first rising edge with reset=1.
- Latency, inputs applied before edge N:
  - `alu_sel`, `alu_out`, `carry_out` valid after edge N (1 cycle).
  - `data_out` valid after edge N+1 (2 cycles).
- Throughput: one instruction per cycle, with no stalls or handshake.
- Reset asserted mid-stream: in-flight instruction and pending writeback are discarded. Outputs follow the reset values above while reset=0.
- Input changes between edges do not affect outputs; the only combinational path is from registers to `alu_out`/`carry_out`.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams OP_ADD=3'b000, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_CMP=3'b111;
  - width constant DATA_W=8.
- Sub-module `alu`: purely combinational (A, B, sel → out, carry). It implements the operation table above.
- `instruction_memory` itself contains the instruction register, the data register, and the `alu` instance.

## Test plan
- Reset: drive reset=0 with random inputs and clock running → all outputs 0 asynchronously. Release reset, apply a=5, b=3, opcode=000 → after 1 edge `alu_out`=8, carry 0; after 2 edges `data_out`=8.
- Sweep with a=5, b=3, one opcode per cycle (000..111). Expected `alu_out` after 1 edge:
  - 000: 8; 001: 2; 010: 1; 011: 7;
  - 100: 6; 101: 15; 110: 1; 111: 8'h01.
  - carry 0 for all; `alu_sel` tracks the opcode; `data_out` lags `alu_out` by one cycle.
- Flags and wrap-around:
  - ADD 200+100 → out 44, carry 1.
  - SUB 3−5 → out 254, carry 1.
  - MUL 20*20 → out 144, carry 1.
- Division edges:
  - DIV 7/2 → 3, carry 0.
  - DIV 9/0 → 8'hFF, carry 1.
- CMP cases:
  - 3 vs 5 → 8'h04, carry 1.
  - 5 vs 5 → 8'h02, carry 0.
  - 9 vs 1 → 8'h01, carry 0.
- Mid-stream reset: assert reset between edges during the sweep → outputs clear immediately without a clock edge. After release, the first edge loads new inputs correctly.
